// File: rtl/idex_buffer_pkg.sv
// Shared widths, sentinel encodings and the buffered-instruction record for
// the decode-to-execute buffer.
package scipio_pkg;

    localparam int COMMON_W    = 32;
    localparam int TAG_W       = 5;
    localparam int OP_W        = 6;
    localparam int EX_UNIT_NUM = 4;
    localparam int EX_UNIT_W   = 2;

    localparam logic [TAG_W-1:0]     TAG_INVALID = '0;
    localparam logic [EX_UNIT_W-1:0] EX_ERR_UNIT = '0;

    typedef struct packed {
        logic [EX_UNIT_W-1:0]       ex_unit;
        logic [OP_W-1:0]            op;
        logic [1:2][TAG_W-1:0]      tag;
        logic [1:2][COMMON_W-1:0]   val;
        logic [TAG_W-1:0]           target;
    } idex_entry_t;

endpackage

// File: rtl/idex_buffer_wakeup.sv
// Operand wakeup: replaces a pending tag with the broadcast value when the
// common data bus announces that tag.
module idex_wakeup
    import scipio_pkg::*;
(
    input  logic [TAG_W-1:0]    tag,
    input  logic [COMMON_W-1:0] val,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic [COMMON_W-1:0] wb_val,
    output logic [TAG_W-1:0]    woken_tag,
    output logic [COMMON_W-1:0] woken_val
);

    logic hit;

    // A ready operand (TAG_INVALID) can never match because wb_tag is excluded too.
    assign hit       = wb_valid && (wb_tag != TAG_INVALID) && (tag == wb_tag);
    assign woken_tag = hit ? TAG_INVALID : tag;
    assign woken_val = hit ? wb_val : val;

endmodule

// File: rtl/idex_buffer.sv
// Two-entry FIFO between decode and the reservation stations, with operand
// wakeup on stored entries, on the incoming entry and on the head output.
module idex_buffer
    import scipio_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rst_tag,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EX_UNIT_W-1:0]   in_ex_unit,
    input  logic [OP_W-1:0]        in_op,
    input  logic [TAG_W-1:0]       in_tag1,
    input  logic [TAG_W-1:0]       in_tag2,
    input  logic [COMMON_W-1:0]    in_val1,
    input  logic [COMMON_W-1:0]    in_val2,
    input  logic [TAG_W-1:0]       in_target,
    input  logic                   wb_valid,
    input  logic [TAG_W-1:0]       wb_tag,
    input  logic [COMMON_W-1:0]    wb_val,
    input  logic [EX_UNIT_NUM-1:0] rs_full,
    output logic [EX_UNIT_NUM-1:0] out_valid,
    output logic [OP_W-1:0]        out_op,
    output logic [TAG_W-1:0]       out_tag1,
    output logic [TAG_W-1:0]       out_tag2,
    output logic [COMMON_W-1:0]    out_val1,
    output logic [COMMON_W-1:0]    out_val2,
    output logic [TAG_W-1:0]       out_target
);

    idex_entry_t       mem [2];
    idex_entry_t       head_e;
    idex_entry_t       in_wk;
    logic              head;
    logic              tail;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    logic [TAG_W-1:0]    in_tag_raw [1:2];
    logic [COMMON_W-1:0] in_val_raw [1:2];
    logic [TAG_W-1:0]    in_tag_wk  [1:2];
    logic [COMMON_W-1:0] in_val_wk  [1:2];
    logic [TAG_W-1:0]    st_tag_wk  [2][1:2];
    logic [COMMON_W-1:0] st_val_wk  [2][1:2];
    logic [TAG_W-1:0]    hd_tag_wk  [1:2];
    logic [COMMON_W-1:0] hd_val_wk  [1:2];

    assign in_tag_raw[1] = in_tag1;
    assign in_tag_raw[2] = in_tag2;
    assign in_val_raw[1] = in_val1;
    assign in_val_raw[2] = in_val2;
    assign head_e        = mem[head];

    for (genvar k = 1; k <= 2; k++) begin : g_opnd
        idex_wakeup u_in_wk (
            .tag(in_tag_raw[k]), .val(in_val_raw[k]),
            .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
            .woken_tag(in_tag_wk[k]), .woken_val(in_val_wk[k])
        );
        idex_wakeup u_hd_wk (
            .tag(head_e.tag[k]), .val(head_e.val[k]),
            .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
            .woken_tag(hd_tag_wk[k]), .woken_val(hd_val_wk[k])
        );
        for (genvar i = 0; i < 2; i++) begin : g_slot
            idex_wakeup u_st_wk (
                .tag(mem[i].tag[k]), .val(mem[i].val[k]),
                .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
                .woken_tag(st_tag_wk[i][k]), .woken_val(st_val_wk[i][k])
            );
        end
    end

    always_comb begin
        in_wk         = '0;
        in_wk.ex_unit = in_ex_unit;
        in_wk.op      = in_op;
        in_wk.tag[1]  = in_tag_wk[1];
        in_wk.tag[2]  = in_tag_wk[2];
        in_wk.val[1]  = in_val_wk[1];
        in_wk.val[2]  = in_val_wk[2];
        in_wk.target  = in_target;
    end

    // Readiness depends only on occupancy; reset holds it low.
    assign in_ready = rst && (count != 2'd2);
    assign push     = in_valid && in_ready && (in_ex_unit != EX_ERR_UNIT) && !rst_tag;

    always_comb begin
        out_valid = '0;
        if (!rst_tag && (count != 2'd0) && !rs_full[head_e.ex_unit])
            out_valid[head_e.ex_unit] = 1'b1;
    end

    assign pop        = |out_valid;
    assign out_op     = head_e.op;
    assign out_target = head_e.target;
    assign out_tag1   = hd_tag_wk[1];
    assign out_tag2   = hd_tag_wk[2];
    assign out_val1   = hd_val_wk[1];
    assign out_val2   = hd_val_wk[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            // Wakeup runs on every slot, even a blocked head or a flushed buffer.
            for (int i = 0; i < 2; i++) begin
                for (int k = 1; k <= 2; k++) begin
                    mem[i].tag[k] <= st_tag_wk[i][k];
                    mem[i].val[k] <= st_val_wk[i][k];
                end
            end
            if (rst_tag) begin
                count <= 2'd0;
                head  <= 1'b0;
                tail  <= 1'b0;
            end else begin
                if (push) begin
                    mem[tail] <= in_wk;
                    tail      <= ~tail;
                end
                if (pop) head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_idex_buffer.sv
// Bench for idex_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_idex_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_tag;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ex_unit;
    logic [5:0]  in_op;
    logic [4:0]  in_tag1, in_tag2, in_target;
    logic [31:0] in_val1, in_val2;
    logic        wb_valid;
    logic [4:0]  wb_tag;
    logic [31:0] wb_val;
    logic [3:0]  rs_full;
    logic [3:0]  out_valid;
    logic [5:0]  out_op;
    logic [4:0]  out_tag1, out_tag2, out_target;
    logic [31:0] out_val1, out_val2;

    idex_buffer dut (
        .clk(clk), .rst(rst), .rst_tag(rst_tag),
        .in_valid(in_valid), .in_ready(in_ready), .in_ex_unit(in_ex_unit),
        .in_op(in_op), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_val1(in_val1), .in_val2(in_val2), .in_target(in_target),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .rs_full(rs_full), .out_valid(out_valid), .out_op(out_op),
        .out_tag1(out_tag1), .out_tag2(out_tag2),
        .out_val1(out_val1), .out_val2(out_val2), .out_target(out_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  u;
        logic [5:0]  op;
        logic [4:0]  t1, t2, tg;
        logic [31:0] v1, v2;
    } ent_t;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic ent_t wake(ent_t e);
        ent_t r = e;
        if (wb_valid && wb_tag != 0) begin
            if (r.t1 == wb_tag) begin r.t1 = 0; r.v1 = wb_val; end
            if (r.t2 == wb_tag) begin r.t2 = 0; r.v2 = wb_val; end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] u, input logic [5:0] op,
                          input logic [4:0] t1, input logic [4:0] t2,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] tg);
        in_valid = v; in_ex_unit = u; in_op = op; in_tag1 = t1; in_tag2 = t2;
        in_val1 = v1; in_val2 = v2; in_target = tg;
    endtask

    // Compare against the model, advance the model across one clock edge.
    task automatic cycle();
        ent_t       h, ni;
        logic [3:0] ev;
        logic       er;
        #2;
        er = (q.size() < 2);
        ev = '0;
        if (!rst_tag && q.size() > 0 && !rs_full[q[0].u]) ev[q[0].u] = 1'b1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
        if (q.size() > 0) begin
            h = wake(q[0]);
            chk("out_op", {26'd0, out_op}, {26'd0, h.op});
            chk("out_tag1", {27'd0, out_tag1}, {27'd0, h.t1});
            chk("out_tag2", {27'd0, out_tag2}, {27'd0, h.t2});
            chk("out_val1", out_val1, h.v1);
            chk("out_val2", out_val2, h.v2);
            chk("out_target", {27'd0, out_target}, {27'd0, h.tg});
        end
        if (rst_tag) q.delete();
        else begin
            foreach (q[i]) q[i] = wake(q[i]);
            if (ev != 0) void'(q.pop_front());
            if (in_valid && er && in_ex_unit != 0) begin
                ni = '{u: in_ex_unit, op: in_op, t1: in_tag1, t2: in_tag2,
                       tg: in_target, v1: in_val1, v2: in_val2};
                q.push_back(wake(ni));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst out_tag1", {27'd0, out_tag1}, 32'd0);
        chk("rst out_val1", out_val1, 32'd0);
        chk("rst out_val2", out_val2, 32'd0);
        chk("rst out_target", {27'd0, out_target}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; rst_tag = 1'b0; wb_valid = 1'b0; wb_tag = '0; wb_val = '0;
        rs_full = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_valid", {28'd0, out_valid}, 32'd0);

        // Basic accept, visible one cycle later.
        set_in(1, 2'd1, 6'd3, 0, 0, 32'd5, 32'd7, 5'd4);
        chk("no bypass", {28'd0, out_valid}, 32'd0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("first out_valid", {28'd0, out_valid}, 32'h2);
        chk("first out_val1", out_val1, 32'd5);
        chk("first out_val2", out_val2, 32'd7);
        chk("first out_target", {27'd0, out_target}, 32'd4);
        cycle();

        // Backpressure: two stored, third held upstream, then in-order drain.
        rs_full = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            set_in(1, 2'd1, 6'd1, 0, 0, 32'd10 + 32'(k), 32'd0, 5'd1);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp out_valid", {28'd0, out_valid}, 32'd0);
        rs_full = '0;
        #1;
        chk("bp drain1 val1", out_val1, 32'd10);
        cycle();
        chk("bp drain2 val1", out_val1, 32'd11);
        chk("bp drain2 valid", {28'd0, out_valid}, 32'h2);
        cycle();

        // Wakeup of both stored entries while the head is blocked.
        rs_full = 4'b0010;
        set_in(1, 2'd1, 6'd2, 5'd6, 5'd0, 32'd0, 32'd1, 5'd2);
        cycle();
        set_in(1, 2'd1, 6'd2, 5'd0, 5'd6, 32'd2, 32'd0, 5'd3);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_tag = 5'd6; wb_val = 32'hAA;
        cycle();
        wb_valid = 1'b0;
        #2;
        chk("wk head tag1", {27'd0, out_tag1}, 32'd0);
        chk("wk head val1", out_val1, 32'hAA);
        rs_full = '0;
        cycle();
        chk("wk second tag2", {27'd0, out_tag2}, 32'd0);
        chk("wk second val2", out_val2, 32'hAA);
        cycle();

        // Broadcast coinciding with dispatch.
        set_in(1, 2'd2, 6'd5, 5'd0, 5'd9, 32'd1, 32'd0, 5'd7);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_tag = 5'd9; wb_val = 32'h55;
        #2;
        chk("same-cycle valid", {28'd0, out_valid}, 32'h4);
        chk("same-cycle tag2", {27'd0, out_tag2}, 32'd0);
        chk("same-cycle val2", out_val2, 32'h55);
        cycle();
        wb_valid = 1'b0;

        // Flush with an offer pending, then an EX_ERR_UNIT bubble.
        rs_full = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            set_in(1, 2'd3, 6'd1, 0, 0, 32'(k), 0, 5'd1);
            cycle();
        end
        rs_full = '0;
        rst_tag = 1'b1;
        set_in(1, 2'd3, 6'd1, 0, 0, 32'd99, 0, 5'd1);
        #2;
        chk("flush forces out_valid", {28'd0, out_valid}, 32'd0);
        cycle();
        rst_tag = 1'b0;
        set_in(1, 2'd0, 6'd1, 0, 0, 32'd1, 0, 5'd1);
        #2;
        chk("flush empties valid", {28'd0, out_valid}, 32'd0);
        chk("flush empties ready", {31'd0, in_ready}, 32'd1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("bubble not stored", {28'd0, out_valid}, 32'd0);
        cycle();

        // Randomized traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                rst = 1'b0;
                #2;
                chk_reset_outputs();
                q.delete();
                @(posedge clk); #1;
                rst = 1'b1;
            end
            set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 6'($urandom),
                   5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                   $urandom, $urandom, 5'($urandom));
            wb_valid = $urandom_range(0, 1);
            wb_tag   = 5'($urandom_range(0, 5));
            wb_val   = $urandom;
            rs_full  = 4'($urandom);
            rst_tag  = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_buffer.md
IDEX_BUFFER -- requirements
Module: idex_buffer

Interface
REQ-001 Parameters (scipio_pkg): COMMON_W=32 (operand width); TAG_W=5 (ROB tag width); TAG_INVALID=0 (operand ready); OP_W=6 (op code); EX_UNIT_NUM=4 (unit count); EX_UNIT_W=2; EX_ERR_UNIT=0 (no instruction).
REQ-002 Ports, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rst_tag  in  1  synchronous flush on mispredict.
- in_valid  in  1  decode stage offers an instruction.
- in_ready  out  1  buffer can accept; upstream stall_if = ~in_ready.
- in_ex_unit  in  EX_UNIT_W  target execution unit.
- in_op  in  OP_W  operation.
- in_tag1, in_tag2  in  TAG_W  source tags.
- in_val1, in_val2  in  COMMON_W  source values.
- in_target  in  TAG_W  destination ROB tag.
- wb_valid  in  1  CDB broadcast valid.
- wb_tag  in  TAG_W  CDB tag.
- wb_val  in  COMMON_W  CDB value.
- rs_full  in  EX_UNIT_NUM  per-unit reservation-station full.
- out_valid  out  EX_UNIT_NUM  one-hot dispatch strobe.
- out_op, out_tag1, out_tag2, out_val1, out_val2, out_target  out  as inputs  head entry after wakeup.

Function
REQ-003 Storage: 2-entry FIFO (head/tail pointers, 2-bit count 0..2).
REQ-004 Accept: in_valid & in_ready & in_ex_unit!=EX_ERR_UNIT writes tail at clk rise; EX_ERR_UNIT inputs are consumed but not stored.
REQ-005 in_ready = (count!=2), a registered-state function only; it does not depend on rs_full or wb.
REQ-006 Latency: an accepted entry drives out_valid at the earliest on the next cycle; there is no input-to-output bypass.
REQ-007 out_valid[u]=1 only when count>0, head.ex_unit==u and rs_full[u]==0; all bits are 0 otherwise.
REQ-008 Dispatch: out_valid asserted at clk rise pops the head; RS captures the out_* fields the same edge.
REQ-009 Accept and dispatch in one cycle: count unchanged, pointers both advance.
REQ-010 Wakeup: while wb_valid, every stored operand with tag==wb_tag (tag!=TAG_INVALID) sets tag=TAG_INVALID and val=wb_val at clk rise.
REQ-011 An input being accepted receives the same wakeup before it is stored.
REQ-012 Output bypass: out_tagN/out_valN show the head operand with the REQ-010 substitution applied combinationally, so a dispatch coinciding with a broadcast is never stale.
REQ-013 wb_tag==TAG_INVALID never matches.
REQ-014 Flush: rst_tag=1 sets count=0 and pointers=0 at clk rise, and overrides accept and dispatch that cycle.
REQ-015 While rst_tag=1, out_valid is forced to all-zero combinationally.
REQ-016 Head blocked by rs_full does not block wakeup of either entry; there is no reordering (strict FIFO).
REQ-017 Pointers wrap modulo 2; count never exceeds 2 or drops below 0.

Reset
REQ-018 rst low asynchronously clears count, pointers, all stored tags to TAG_INVALID and all values to 0.
REQ-019 During reset: in_ready=0, out_valid=0, all out_* fields 0.
REQ-020 First accept is possible on the first clk rise after rst deasserts.
REQ-021 Reset mid-operation discards buffered entries; no partial dispatch occurs.

Structure
REQ-022 All widths, TAG_INVALID and EX_ERR_UNIT live in scipio_pkg; an entry struct (ex_unit, op, tag[1:2], val[1:2], target) is defined there.
REQ-023 One sub-module, idex_wakeup: combinational tag compare and substitute for one operand, instantiated per stored operand, per input operand and per output bypass.

Verification
REQ-024 Reset: rst=0, then release -> out_valid=0000, in_ready=1; accept (unit 1, op 3, tags 0/0, vals 5/7, target 4) -> next cycle out_valid=0010, out_val1=5, out_val2=7, out_target=4.
REQ-025 Backpressure: rs_full=0010, 3 offers to unit 1 -> two stored, in_ready=0, third held upstream; release rs_full -> dispatch in order at one per cycle.
REQ-026 Wakeup while stored: head tag1=6 blocked, wb(6, 0xAA) -> head tag1=0, val1=0xAA; second entry with tag2=6 also woken.
REQ-027 Same-cycle wakeup and dispatch: head tag2=9, rs_full=0, wb(9, 0x55) -> out_tag2=0, out_val2=0x55 on the dispatch edge.
REQ-028 Flush and bubble: 2 entries held, rst_tag=1 with in_valid=1 -> count=0, out_valid=0 next cycle, input dropped; in_ex_unit=EX_ERR_UNIT -> nothing stored.
